// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order imem responses buffered with PCs, redirect flush.
// Optional same-cycle response-to-dequeue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic [31:0]   in_flight;
    logic          req_fire;
    logic          rsp_keep;
    logic          bypass;
    logic          head_valid;
    logic          fifo_deq;
    logic          wr_en;
    logic [OW-1:0] outstanding_next;
    logic [CW-1:0] count_next;

    // Credit counts words already queued plus live requests; dropped ones will never land.
    assign in_flight      = 32'(count) + 32'(outstanding) - 32'(drop);
    assign imem_req_valid = (32'(outstanding) < MAX_OUTSTANDING) && (in_flight < DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (drop == '0);
    assign head_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_keep && !head_valid && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        deq_valid = head_valid;
        deq_pc    = head_valid ? mem_pc[rd_ptr]    : 32'h0;
        deq_instr = head_valid ? mem_instr[rd_ptr] : 32'h0;
        if (bypass) begin
            deq_valid = 1'b1;
            deq_pc    = rsp_pc;
            deq_instr = imem_rsp_data;
        end
    end

    assign fifo_deq  = head_valid && deq_ready;
    assign wr_en     = rsp_keep && !redirect_valid && (count != CW'(DEPTH)) && !(bypass && deq_ready);
    assign count_next       = count + CW'(wr_en) - CW'(fifo_deq);
    assign outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    assign occupancy        = count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= rsp_pc;
            mem_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still unanswered after this cycle belongs to the old stream.
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop     <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid) begin
                    if (drop == '0)
                        rsp_pc <= rsp_pc + 32'd4;
                    else
                        drop <= drop - OW'(1);
                end
                if (wr_en)
                    wr_ptr <= wr_ptr + PW'(1);
                if (fifo_deq)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end
        end
    end

    // Memory must never return a kept word into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(rsp_keep && !redirect_valid && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model and an in-order memory model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  occupancy;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        mq[$];
    pend_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] m_fetch, m_rsp, nxt_pc, first_pc, cyc;
    int          m_out, m_drop, deq_cnt, max_occ;
    int          lat_min, lat_max, rsp_pct;
    bit          want_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_fetch    = RPC;
        m_rsp      = RPC;
        nxt_pc     = RPC;
        m_out      = 0;
        m_drop     = 0;
        want_first = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rq_rdy, input logic dq_rdy);
        logic        e_req, e_deq, byp, rsp, req_fire, deq_fire, was_full;
        logic [31:0] e_pc, e_instr;
        ent_t        e_tmp;
        pend_t       p_tmp;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        deq_ready      = dq_rdy;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(pend[0].addr) : $urandom;
        #1;
        e_req = (m_out < MAXO) && ((mq.size() + m_out - m_drop) < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = rsp && (m_drop == 0) && (mq.size() == 0) && !redir;
`else
        byp = 1'b0;
`endif
        e_deq   = (mq.size() != 0) || byp;
        e_pc    = (mq.size() != 0) ? mq[0].pc    : m_rsp;
        e_instr = (mq.size() != 0) ? mq[0].instr : imem_rsp_data;
        check("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) check("req_addr", imem_req_addr, m_fetch);
        check("deq_valid", 32'(deq_valid), 32'(e_deq));
        if (e_deq) begin
            check("deq_pc", deq_pc, e_pc);
            check("deq_instr", deq_instr, e_instr);
        end
        check("occupancy", 32'(occupancy), mq.size());
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);

        req_fire = e_req && rq_rdy;
        deq_fire = e_deq && dq_rdy;
        if (deq_fire && !redir) begin
            check("seq_pc", deq_pc, nxt_pc);
            check("seq_instr", deq_instr, instr_of(nxt_pc));
            if (want_first) begin
                first_pc   = deq_pc;
                want_first = 1'b0;
            end
            nxt_pc = nxt_pc + 32'd4;
            deq_cnt++;
        end

        if (rsp) p_tmp = pend.pop_front();
        if (req_fire) begin
            pend.push_back('{addr: m_fetch, due: cyc + $urandom_range(lat_max, lat_min)});
            req_log.push_back(imem_req_addr);
        end

        if (redir) begin
            m_out      = m_out + int'(req_fire) - int'(rsp);
            m_drop     = m_out;
            mq.delete();
            m_fetch    = rpc;
            m_rsp      = rpc;
            nxt_pc     = rpc;
            want_first = 1'b1;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (deq_fire && !byp) e_tmp = mq.pop_front();
            if (rsp) begin
                if (m_drop == 0) begin
                    if (!(byp && dq_rdy) && !was_full) mq.push_back('{pc: m_rsp, instr: imem_rsp_data});
                    m_rsp = m_rsp + 32'd4;
                end else begin
                    m_drop--;
                end
            end
            if (req_fire) m_fetch = m_fetch + 32'd4;
            m_out = m_out + int'(req_fire) - int'(rsp);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RPC);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        resetn = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        deq_ready = 1'b0;
        cyc = 0; deq_cnt = 0; max_occ = 0; first_pc = 32'h0;
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_deq_valid", 32'(deq_valid), 32'd0);
        check("reset_deq_pc", deq_pc, 32'd0);
        check("reset_deq_instr", deq_instr, 32'd0);
        resetn = 1'b1;

        // Streaming from RESET_PC at one word per cycle
        repeat (30) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("stream_cnt", deq_cnt, 32'd28);
        check("stream_occ_le2", 32'(max_occ <= 2), 32'd1);

        // Stall until the queue saturates, then drain without gaps
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("sat_occ", 32'(occupancy), 32'd4);
        check("sat_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", 32'(deq_valid), 32'd1);
            step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Long latency, redirect with requests still in flight
        lat_min = 3; lat_max = 3;
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && m_out != 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("two_outstanding", m_out, 32'd2);
        step(1'b1, 32'h0000_2000, 1'b0, 1'b1);
        check("flush_valid", 32'(deq_valid), 32'd0);
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_first", first_pc, 32'h0000_2000);

        // Redirect coinciding with a request handshake and a response
        lat_min = 1; lat_max = 1;
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_3000, 1'b1, 1'b1);
        check("flush2_valid", 32'(deq_valid), 32'd0);
        check("flush2_occ", 32'(occupancy), 32'd0);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("redir2_first", first_pc, 32'h0000_3000);

        // Fetch address wraps past the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        req_log.delete();
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_cnt", 32'(req_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) begin
            check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", req_log[2], 32'h0000_0000);
        end

        // Random traffic with redirects and one mid-run reset
        lat_min = 1; lat_max = 4; rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [31:0] tgt;
            if (i == 1500) mid_reset();
            rd  = ($urandom_range(19) == 0);
            tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + {$urandom_range(3), 2'b00}
                                           : {$urandom, 2'b00} & 32'hFFFF_FFFC;
            step(rd, tgt, $urandom_range(99) < 75, $urandom_range(99) < 70);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
